// File: rtl/elc3_mem_pkg.sv
// Shared types and memory-map constants for the eLC-3 memory responder.
package elc3_mem_pkg;

  typedef enum logic [1:0] {IDLE, RAM, IO, DONE} mem_state_t;

  localparam logic [15:0] KBSR_ADDR = 16'hFE00;
  localparam logic [15:0] KBDR_ADDR = 16'hFE02;
  localparam logic [15:0] DSR_ADDR  = 16'hFE04;
  localparam logic [15:0] DDR_ADDR  = 16'hFE06;
  localparam logic [15:0] MCR_ADDR  = 16'hFFFE;
  localparam logic [6:0]  IO_PAGE   = 7'h7F;

endpackage

// File: rtl/mmio_regs.sv
// Memory-mapped keyboard/display (and optional MCR, macro ELC3_MCR_EN) registers
// with their device handshakes; accesses take effect in the responder's DONE cycle.
module mmio_regs
  import elc3_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              rd_done,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wr_data,
`ifdef ELC3_MCR_EN
  input  logic              wr_msb,
  output logic              halt,
`endif
  output logic [DATA_W-1:0] rdata_c,
  input  logic              kb_valid,
  input  logic [7:0]        kb_data,
  output logic              disp_valid,
  output logic [7:0]        disp_data,
  input  logic              disp_ready
);

  logic       kbsr_q, kbsr_d;
  logic [7:0] kbdr_q, kbdr_d;
  logic       disp_valid_q, disp_valid_d;
  logic [7:0] disp_data_q, disp_data_d;
  logic       kb_clr;
`ifdef ELC3_MCR_EN
  logic [15:0] mcr_q, mcr_d;
`endif

  // DSR ready is exactly "no character pending", so it is not stored separately.
  always_comb begin
    kbsr_d       = kbsr_q;
    kbdr_d       = kbdr_q;
    disp_valid_d = disp_valid_q;
    disp_data_d  = disp_data_q;
    kb_clr       = rd_done && (addr == ADDR_W'(KBDR_ADDR));
`ifdef ELC3_MCR_EN
    mcr_d        = mcr_q;
`endif
    if (kb_clr)
      kbsr_d = 1'b0;
    if (kb_valid && (!kbsr_q || kb_clr)) begin
      kbsr_d = 1'b1;
      kbdr_d = kb_data;
    end
    if (disp_valid_q && disp_ready)
      disp_valid_d = 1'b0;
    if (wr_en && (addr == ADDR_W'(DDR_ADDR)) && !disp_valid_q) begin
      disp_valid_d = 1'b1;
      disp_data_d  = wr_data;
    end
`ifdef ELC3_MCR_EN
    if (wr_en && (addr == ADDR_W'(MCR_ADDR)) && !wr_msb)
      mcr_d[15] = 1'b0;
`endif
  end

  always_comb begin
    rdata_c = '0;
    if (addr == ADDR_W'(KBSR_ADDR))      rdata_c = DATA_W'({kbsr_q, 15'b0});
    else if (addr == ADDR_W'(KBDR_ADDR)) rdata_c = DATA_W'(kbdr_q);
    else if (addr == ADDR_W'(DSR_ADDR))  rdata_c = DATA_W'({!disp_valid_q, 15'b0});
`ifdef ELC3_MCR_EN
    else if (addr == ADDR_W'(MCR_ADDR))  rdata_c = DATA_W'(mcr_q);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kbsr_q       <= 1'b0;
      kbdr_q       <= 8'h00;
      disp_valid_q <= 1'b0;
      disp_data_q  <= 8'h00;
`ifdef ELC3_MCR_EN
      mcr_q        <= 16'h8000;
`endif
    end else begin
      kbsr_q       <= kbsr_d;
      kbdr_q       <= kbdr_d;
      disp_valid_q <= disp_valid_d;
      disp_data_q  <= disp_data_d;
`ifdef ELC3_MCR_EN
      mcr_q        <= mcr_d;
`endif
    end
  end

  assign disp_valid = disp_valid_q;
  assign disp_data  = disp_data_q;
`ifdef ELC3_MCR_EN
  assign halt = ~mcr_q[15];
`endif

endmodule

// File: rtl/mem_io_responder.sv
// eLC-3 memory target: routes MIO_EN accesses to wait-stated async SRAM or MMIO registers
// and pulses R on completion. Macro ELC3_MCR_EN adds the MCR register and halt output.
module mem_io_responder
  import elc3_mem_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 16
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              MIO_EN,
  input  logic              R_W,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] Data_In,
  output logic [DATA_W-1:0] Data_Out,
  output logic              R,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  input  logic              kb_valid,
  input  logic [7:0]        kb_data,
  output logic              disp_valid,
  output logic [7:0]        disp_data,
  input  logic              disp_ready
`ifdef ELC3_MCR_EN
  , output logic            halt
`endif
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(WAIT_CYCLES - 1);
  // A one-cycle write still needs we_n to rise before ce_n, so it gets two cycles.
  localparam logic [CNT_W-1:0] WR_LAST = (WAIT_CYCLES == 1) ? CNT_W'(1) : RD_LAST;

  mem_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rw_q, rw_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              r_q, r_d;
  logic              ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
  logic              io_q, mmio_wr, mmio_rd;
  logic [DATA_W-1:0] mmio_rdata;

  assign io_q = (addr_q[ADDR_W-1 -: 7] == IO_PAGE);

  // Next state, captured access fields and read data.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    wdata_d = wdata_q;
    dout_d  = dout_q;
    mmio_wr = 1'b0;
    mmio_rd = 1'b0;
    case (state_q)
      IDLE: if (MIO_EN) begin
        addr_d  = Addr;
        rw_d    = R_W;
        wdata_d = Data_In;
        cnt_d   = '0;
        state_d = (Addr[ADDR_W-1 -: 7] == IO_PAGE) ? IO : RAM;
      end
      RAM: if (cnt_q == (rw_q ? WR_LAST : RD_LAST)) begin
        state_d = DONE;
        cnt_d   = '0;
        if (!rw_q) dout_d = sram_rdata;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      IO: begin
        state_d = DONE;
        if (!rw_q) dout_d = mmio_rdata;
      end
      DONE: begin
        state_d = IDLE;
        mmio_wr = rw_q && io_q;
        mmio_rd = !rw_q && io_q;
      end
      default: state_d = IDLE;
    endcase
    r_d    = (state_d == DONE);
    ce_n_d = !(state_d == RAM);
    oe_n_d = !((state_d == RAM) && !rw_d);
    we_n_d = !((state_d == RAM) && rw_d && (cnt_d != WR_LAST));
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
      dout_q  <= '0;
      r_q     <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
      r_q     <= r_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
    end
  end

  mmio_regs #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mmio (
    .clk        (Clk),
    .rst_n      (Reset_n),
    .wr_en      (mmio_wr),
    .rd_done    (mmio_rd),
    .addr       (addr_q),
    .wr_data    (wdata_q[7:0]),
`ifdef ELC3_MCR_EN
    .wr_msb     (wdata_q[15]),
    .halt       (halt),
`endif
    .rdata_c    (mmio_rdata),
    .kb_valid   (kb_valid),
    .kb_data    (kb_data),
    .disp_valid (disp_valid),
    .disp_data  (disp_data),
    .disp_ready (disp_ready)
  );

  assign Data_Out   = dout_q;
  assign R          = r_q;
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;
  assign sram_ce_n  = ce_n_q;
  assign sram_oe_n  = oe_n_q;
  assign sram_we_n  = we_n_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed scoreboard bench for mem_io_responder (define ELC3_MCR_EN to cover MCR/halt).
module tb_mem_io_responder;

  localparam int unsigned WAIT = 2;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        MIO_EN = 1'b0;
  logic        R_W = 1'b0;
  logic [15:0] Addr = '0;
  logic [15:0] Data_In = '0;
  logic [15:0] Data_Out;
  logic        R;
  logic [15:0] sram_addr, sram_wdata;
  logic [15:0] sram_rdata = '0;
  logic        sram_ce_n, sram_oe_n, sram_we_n;
  logic        kb_valid = 1'b0;
  logic [7:0]  kb_data = '0;
  logic        disp_valid;
  logic [7:0]  disp_data;
  logic        disp_ready = 1'b0;
`ifdef ELC3_MCR_EN
  logic        halt;
`endif

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  mem_io_responder #(.WAIT_CYCLES(WAIT), .ADDR_W(16), .DATA_W(16)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .MIO_EN(MIO_EN), .R_W(R_W), .Addr(Addr),
    .Data_In(Data_In), .Data_Out(Data_Out), .R(R), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .kb_valid(kb_valid),
    .kb_data(kb_data), .disp_valid(disp_valid), .disp_data(disp_data),
    .disp_ready(disp_ready)
`ifdef ELC3_MCR_EN
    , .halt(halt)
`endif
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One access: pushes the expected read value, then checks latency, strobes and data on R.
  task automatic access(input string tag, input logic rw, input logic [15:0] a,
                        input logic [15:0] d, input logic [15:0] rd_exp);
    logic        io;
    logic        seen;
    int          ce, oe, we, lat;
    int          exp_ce, exp_oe, exp_we, exp_lat;
    logic [15:0] e;
    logic [15:0] held;
    io = (a[15:9] == 7'h7F);
    seen = 1'b0; ce = 0; oe = 0; we = 0; lat = 0;
    exp_ce  = io ? 0 : int'(WAIT);
    exp_oe  = (!io && !rw) ? int'(WAIT) : 0;
    exp_we  = (!io && rw) ? int'(WAIT) - 1 : 0;
    exp_lat = io ? 2 : int'(WAIT) + 1;
    if (!rw) exp_q.push_back(rd_exp);
    held = Data_Out;
    @(negedge Clk);
    MIO_EN = 1'b1; R_W = rw; Addr = a; Data_In = d;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge Clk);
      lat++;
      if (R) seen = 1'b1;
      else begin
        if (!sram_ce_n) ce++;
        if (!sram_oe_n) oe++;
        if (!sram_we_n) we++;
        if (lat == 1 && !io) begin
          chk({tag, "_sram_addr"}, 32'(sram_addr), 32'(a));
          if (rw) chk({tag, "_sram_wdata"}, 32'(sram_wdata), 32'(d));
        end
        Addr = ~a; Data_In = ~d;
      end
    end
    MIO_EN = 1'b0;
    chk({tag, "_R_seen"}, 32'(seen), 32'd1);
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_ce_cycles"}, 32'(ce), 32'(exp_ce));
    chk({tag, "_oe_cycles"}, 32'(oe), 32'(exp_oe));
    chk({tag, "_we_cycles"}, 32'(we), 32'(exp_we));
    if (!rw) begin
      e = exp_q.pop_front();
      if (seen) chk({tag, "_data"}, 32'(Data_Out), 32'(e));
    end else begin
      chk({tag, "_data_held"}, 32'(Data_Out), 32'(held));
    end
    @(negedge Clk);
    chk({tag, "_R_pulse"}, 32'(R), 32'd0);
  endtask

  initial begin
    int r_count;
    // Power-on reset, then an asynchronous mid-cycle reset pulse of 3 cycles.
    repeat (2) @(posedge Clk);
    #2 Reset_n = 1'b1;
    repeat (2) @(posedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    chk("rst_R", 32'(R), 32'd0);
    chk("rst_ce_n", 32'(sram_ce_n), 32'd1);
    chk("rst_oe_n", 32'(sram_oe_n), 32'd1);
    chk("rst_we_n", 32'(sram_we_n), 32'd1);
    chk("rst_disp_valid", 32'(disp_valid), 32'd0);
    chk("rst_data_out", 32'(Data_Out), 32'd0);
    chk("rst_sram_addr", 32'(sram_addr), 32'd0);
    repeat (3) @(posedge Clk);
    #3 Reset_n = 1'b1;
    access("dsr_after_rst", 1'b0, 16'hFE04, 16'h0000, 16'h8000);

    // SRAM read, write, second read with a different pattern.
    sram_rdata = 16'h1234;
    access("ram_rd", 1'b0, 16'h3000, 16'h0000, 16'h1234);
    access("ram_wr", 1'b1, 16'h4000, 16'hBEEF, 16'h0000);
    sram_rdata = 16'h5555;
    access("ram_rd0", 1'b0, 16'h0000, 16'h0000, 16'h5555);
    sram_rdata = 16'hA5A5;
    access("ram_rd_top", 1'b0, 16'hFDFF, 16'h0000, 16'hA5A5);

    // Keyboard: first key latched, second dropped, KBDR read clears ready.
    @(negedge Clk); kb_valid = 1'b1; kb_data = 8'h41;
    @(negedge Clk); kb_valid = 1'b0;
    access("kbsr_set", 1'b0, 16'hFE00, 16'h0000, 16'h8000);
    @(negedge Clk); kb_valid = 1'b1; kb_data = 8'h42;
    @(negedge Clk); kb_valid = 1'b0;
    access("kbdr_rd", 1'b0, 16'hFE02, 16'h0000, 16'h0041);
    access("kbsr_clr", 1'b0, 16'hFE00, 16'h0000, 16'h0000);
    access("kbsr_wr", 1'b1, 16'hFE00, 16'h8000, 16'h0000);
    access("kbsr_ign", 1'b0, 16'hFE00, 16'h0000, 16'h0000);

    // Display: first write accepted, second discarded, handshake restores ready.
    access("ddr_wr1", 1'b1, 16'hFE06, 16'h0058, 16'h0000);
    chk("disp_valid_set", 32'(disp_valid), 32'd1);
    chk("disp_data_58", 32'(disp_data), 32'h58);
    access("dsr_busy", 1'b0, 16'hFE04, 16'h0000, 16'h0000);
    access("ddr_wr2", 1'b1, 16'hFE06, 16'h0059, 16'h0000);
    chk("disp_data_kept", 32'(disp_data), 32'h58);
    @(negedge Clk); disp_ready = 1'b1;
    @(negedge Clk); disp_ready = 1'b0;
    chk("disp_valid_clr", 32'(disp_valid), 32'd0);
    access("dsr_ready", 1'b0, 16'hFE04, 16'h0000, 16'h8000);
    access("io_unmapped", 1'b0, 16'hFE08, 16'h0000, 16'h0000);

`ifdef ELC3_MCR_EN
    chk("halt_init", 32'(halt), 32'd0);
    access("mcr_rd_init", 1'b0, 16'hFFFE, 16'h0000, 16'h8000);
    access("mcr_wr", 1'b1, 16'hFFFE, 16'h0000, 16'h0000);
    chk("halt_set", 32'(halt), 32'd1);
    access("mcr_rd", 1'b0, 16'hFFFE, 16'h0000, 16'h0000);
`else
    access("xfffe_unmapped", 1'b0, 16'hFFFE, 16'h0000, 16'h0000);
`endif

    // Reset in the middle of a RAM read abandons it.
    sram_rdata = 16'h7777;
    @(negedge Clk); MIO_EN = 1'b1; R_W = 1'b0; Addr = 16'h3000;
    @(negedge Clk);
    chk("midrst_ce_active", 32'(sram_ce_n), 32'd0);
    #2 Reset_n = 1'b0;
    #1;
    chk("midrst_ce_n", 32'(sram_ce_n), 32'd1);
    chk("midrst_oe_n", 32'(sram_oe_n), 32'd1);
    chk("midrst_R", 32'(R), 32'd0);
    chk("midrst_data_out", 32'(Data_Out), 32'd0);
    MIO_EN = 1'b0;
    repeat (2) @(posedge Clk);
    #2 Reset_n = 1'b1;
    r_count = 0;
    repeat (6) begin
      @(negedge Clk);
      if (R) r_count++;
    end
    chk("midrst_no_R", 32'(r_count), 32'd0);
    chk("midrst_data_kept", 32'(Data_Out), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
